flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Consumer end of the 64-bit ALU flag interface.
- Captures N/Z/V/C from the ALU into an architectural flags register on flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves B.cond, CBZ, CBNZ and B branch requests against stored, forwarded or in-flight flags.
- Returns a registered taken/not-taken decision to fetch through a valid/ready handshake.

Parameters:
- FLUSH_KILLS_WAIT, 1, when 1 a flush aborts a request stalled in WAIT_FLAGS; when 0 the flush is ignored while waiting.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_negative  in  1  ALU negative flag, current cycle.
- alu_zero  in  1  ALU zero flag, current cycle.
- alu_overflow  in  1  ALU overflow flag, current cycle.
- alu_carry_out  in  1  ALU carry_out flag, current cycle.
- set_flags  in  1  write ALU flags into the flags register at this edge.
- flags_busy  in  1  a multi-cycle flag-setting op is in flight; flags are not yet valid.
- flush  in  1  pipeline flush; kills the current or pending request.
- br_valid  in  1  branch request present.
- br_ready  out  1  unit can accept a request this cycle.
- br_type  in  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ.
- br_cond  in  4  ARM condition code, used for B.cond only.
- dec_valid  out  1  decision valid; a one-cycle pulse.
- dec_taken  out  1  branch taken, qualified by dec_valid.
- flags_q  out  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (async assert, sync release): flags_q=4'b0000, state=IDLE, dec_valid=0, dec_taken=0, br_ready=1.
- Flags register:
  - On a clk edge with set_flags=1, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - Otherwise flags_q holds.
  - set_flags is honoured in every state, including during flush.
- Effective flags for evaluation: if set_flags=1 in the same cycle, use the live ALU flags (forwarded); else use flags_q.
- Condition evaluation (N,Z,C,V = effective flags):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C.
  - MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V.
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 true; NV 1111 true (ARMv8 semantics).
- CBZ/CBNZ: the register value passes through ALU PASS_B, so taken = alu_zero / !alu_zero in the accept cycle. They never stall on flags_busy.
- B: always taken, never stalls.
- State machine:
  - IDLE:
    - br_ready=1.
    - A handshake occurs when br_valid & br_ready & !flush.
    - If the request is B.cond & flags_busy: latch br_cond and go to WAIT_FLAGS.
    - Otherwise go to RESP with dec_taken evaluated.
  - WAIT_FLAGS:
    - br_ready=0.
    - Leave on the cycle flags_busy=0 & set_flags=1: evaluate the latched cond against the forwarded flags and go to RESP.
    - If flags_busy=0 without set_flags, evaluate against flags_q and go to RESP.
    - flush with FLUSH_KILLS_WAIT=1: go to IDLE, no decision produced.
  - RESP:
    - dec_valid=1 for exactly one cycle, dec_taken registered, br_ready=1.
    - Back-to-back handshakes are permitted: a new accept in RESP loads the next RESP or WAIT_FLAGS.
    - Otherwise go to IDLE.
- Latency: decision appears the cycle after the handshake when not stalled; one cycle after flags_busy falls when stalled.
- flush in the accept cycle: no handshake, and dec_valid stays 0 next cycle.
- flush during RESP: dec_valid is still asserted; squashing it is fetch's responsibility.
- br_type/br_cond are don't-care when br_valid=0.
- The request must be held stable while br_ready=0 (initiator rule).
- Reset mid-WAIT_FLAGS: return to IDLE, flags cleared, no decision.

Decomposition:
- Shared package (cpu_pkg):
  - Condition code constants COND_EQ..COND_NV.
  - Branch type enum BR_B/BR_COND/BR_CBZ/BR_CBNZ.
  - flags_t packed struct {n,z,c,v}.
  - ALU_* control constants (shared with the ALU).
- Sub-module cond_eval: combinational (flags_t, cond[3:0]) -> pass.
- The top holds the flags register and the FSM.

Test Plan:
- After reset, set_flags=1 with ALU N=0,Z=1,C=1,V=0; next cycle B.cond EQ -> dec_valid pulse one cycle after accept, dec_taken=1, flags_q=4'b0110.
- Same-cycle forwarding: flags_q=0000; set_flags=1 with Z=1 alongside B.cond NE -> dec_taken=0 (uses forwarded Z, not stale flags_q).
- Sweep all 16 conds over all 16 {N,Z,C,V} combinations -> dec_taken matches the table (e.g. N=1,V=0: GE=0, LT=1; C=1,Z=1: HI=0, LS=1; NV=1).
- Stall path: flags_busy=1, issue B.cond GT -> br_ready=0 and no dec_valid for 3 cycles; drop flags_busy with set_flags=1, N=0,Z=0,V=0 -> dec_valid next cycle with dec_taken=1.
- CBZ with alu_zero=1 and CBNZ with alu_zero=1 issued back-to-back -> dec_taken=1 then 0 on consecutive cycles; flags_busy=1 causes no stall.
- Flush in WAIT_FLAGS (FLUSH_KILLS_WAIT=1) -> IDLE with no decision; async reset asserted mid-WAIT_FLAGS -> flags_q=0, br_ready=1, dec_valid=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes, branch kinds, the NZCV flags word and ALU opcodes.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {
      BR_B    = 2'b00,
      BR_COND = 2'b01,
      BR_CBZ  = 2'b10,
      BR_CBNZ = 2'b11
   } br_type_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam logic [3:0] ALU_ADD    = 4'h0;
   localparam logic [3:0] ALU_SUB    = 4'h1;
   localparam logic [3:0] ALU_AND    = 4'h2;
   localparam logic [3:0] ALU_ORR    = 4'h3;
   localparam logic [3:0] ALU_EOR    = 4'h4;
   localparam logic [3:0] ALU_PASS_B = 4'h5;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code check of NZCV flags; zero latency, no backpressure.
module cond_eval
   import cpu_pkg::*;
(
   input  flags_t     flags_i,
   input  logic [3:0] cond_i,
   output logic       pass_o
);

   always_comb begin
      pass_o = 1'b1;
      case (cond_i)
         COND_EQ: pass_o = flags_i.z;
         COND_NE: pass_o = ~flags_i.z;
         COND_CS: pass_o = flags_i.c;
         COND_CC: pass_o = ~flags_i.c;
         COND_MI: pass_o = flags_i.n;
         COND_PL: pass_o = ~flags_i.n;
         COND_VS: pass_o = flags_i.v;
         COND_VC: pass_o = ~flags_i.v;
         COND_HI: pass_o = flags_i.c & ~flags_i.z;
         COND_LS: pass_o = ~flags_i.c | flags_i.z;
         COND_GE: pass_o = (flags_i.n == flags_i.v);
         COND_LT: pass_o = (flags_i.n != flags_i.v);
         COND_GT: pass_o = ~flags_i.z & (flags_i.n == flags_i.v);
         COND_LE: pass_o = flags_i.z | (flags_i.n != flags_i.v);
         // AL and NV both mean "always" in ARMv8
         default: pass_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Flags register plus branch resolver; decision one cycle after accept, or one cycle after flags_busy falls.
// br_ready drops only while a B.cond waits for in-flight flags; dec_valid is a pulse with no downstream stall.
module flag_branch_unit
   import cpu_pkg::*;
#(
   parameter bit FLUSH_KILLS_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       alu_negative,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   input  logic       alu_carry_out,
   input  logic       set_flags,
   input  logic       flags_busy,
   input  logic       flush,
   input  logic       br_valid,
   output logic       br_ready,
   input  logic [1:0] br_type,
   input  logic [3:0] br_cond,
   output logic       dec_valid,
   output logic       dec_taken,
   output logic [3:0] flags_q
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0] state_q, state_d;
   logic       taken_q, taken_d;
   logic [3:0] cond_q, cond_d;

   flags_t     live_flags, eff_flags;
   logic [3:0] cond_sel;
   logic       cond_pass;
   logic       accept;
   logic       accept_taken;
   br_type_e   br_kind;

   assign live_flags = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
   // Flags written this edge are forwarded so a B.cond right behind ADDS sees them.
   assign eff_flags  = set_flags ? live_flags : flags_t'(flags_q);
   assign cond_sel   = (state_q == S_WAIT) ? cond_q : br_cond;
   assign br_kind    = br_type_e'(br_type);

   cond_eval u_cond_eval (
      .flags_i (eff_flags),
      .cond_i  (cond_sel),
      .pass_o  (cond_pass)
   );

   assign br_ready  = (state_q != S_WAIT);
   assign dec_valid = (state_q == S_RESP);
   assign dec_taken = taken_q;
   assign accept    = br_valid & br_ready & ~flush;

   // CBZ/CBNZ operand arrives through ALU PASS_B, so alu_zero is the register-is-zero test.
   always_comb begin
      accept_taken = 1'b1;
      case (br_kind)
         BR_B:    accept_taken = 1'b1;
         BR_COND: accept_taken = cond_pass;
         BR_CBZ:  accept_taken = alu_zero;
         BR_CBNZ: accept_taken = ~alu_zero;
         default: accept_taken = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      taken_d = taken_q;
      cond_d  = cond_q;
      case (state_q)
         S_WAIT: begin
            if (flush && FLUSH_KILLS_WAIT) begin
               state_d = S_IDLE;
            end else if (!flags_busy) begin
               state_d = S_RESP;
               taken_d = cond_pass;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               if (br_kind == BR_COND && flags_busy) begin
                  state_d = S_WAIT;
                  cond_d  = br_cond;
               end else begin
                  state_d = S_RESP;
                  taken_d = accept_taken;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         taken_q <= 1'b0;
         cond_q  <= 4'h0;
         flags_q <= 4'h0;
      end else begin
         state_q <= state_d;
         taken_q <= taken_d;
         cond_q  <= cond_d;
         if (set_flags) begin
            flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
         end
      end
   end

endmodule
